coin_acceptor: RTL and testbench

Front-end coin discriminator that produces the 2-bit coin code consumed by the newspaper vending FSM. It classifies coins by the width of the raw coin-sense pulse from the chute sensor. Output is a one-cycle coin code per accepted coin, so the vending FSM counts each coin exactly once. It also flags invalid coins and chute jams, and keeps a running count of accepted coins.

---
 rtl/vend_pkg.sv | 16 +
 rtl/coin_sense_sync.sv | 28 ++
 rtl/coin_acceptor.sv | 142 ++++++++++++++
 tb/tb_coin_acceptor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin codes and coin-acceptor state encoding for the vending front end.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEASURE  = 3'd1,
        HOLD     = 3'd2,
        COOLDOWN = 3'd3,
        JAM      = 3'd4
    } acc_state_t;

endpackage

// File: rtl/coin_sense_sync.sv
// Two-flop synchronizer for the raw chute sensor plus rising-edge detect.
module coin_sense_sync (
    input  logic clock,
    input  logic reset,
    input  logic coin_sense,
    output logic sense_s,
    output logic rise
);

    logic meta;
    logic sense_r;

    // Synchronizer chain and one-cycle delayed copy for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta    <= 1'b0;
            sense_s <= 1'b0;
            sense_r <= 1'b0;
        end else begin
            meta    <= coin_sense;
            sense_s <= meta;
            sense_r <= sense_s;
        end
    end

    assign rise = sense_s & ~sense_r;

endmodule

// File: rtl/coin_acceptor.sv
// Coin discriminator: classifies coins by sense-pulse width and emits a
// one-cycle coin code, reject pulse, jam level and accepted-coin count.
module coin_acceptor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned NICKEL_MIN = 4,
    parameter int unsigned NICKEL_MAX = 8,
    parameter int unsigned DIME_MIN   = 12,
    parameter int unsigned DIME_MAX   = 20,
    parameter int unsigned JAM_LIMIT  = 64,
    parameter int unsigned COOLDOWN   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_sense,
    input  logic       newspaper,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic [7:0] accepted_count
);

    import vend_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sense_s;
    logic             rise;
    acc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       coin_d;
    logic             reject_d;
    logic             jam_d;
    logic [7:0]       count_d;

    coin_sense_sync u_sync (
        .clock      (clock),
        .reset      (reset),
        .coin_sense (coin_sense),
        .sense_s    (sense_s),
        .rise       (rise)
    );

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cool_q         <= '0;
            code_q         <= COIN_NONE;
            coin           <= COIN_NONE;
            reject         <= 1'b0;
            jam            <= 1'b0;
            accepted_count <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cool_q         <= cool_d;
            code_q         <= code_d;
            coin           <= coin_d;
            reject         <= reject_d;
            jam            <= jam_d;
            accepted_count <= count_d;
        end
    end

    // Next-state, pulse-width measurement and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cool_d   = cool_q;
        code_d   = code_q;
        coin_d   = COIN_NONE;
        reject_d = 1'b0;
        jam_d    = 1'b0;
        count_d  = accepted_count;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end

            MEASURE: begin
                if (sense_s) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (32'(cnt_d) == JAM_LIMIT) begin
                        state_d = JAM;
                        jam_d   = 1'b1;
                    end
                end else if (32'(cnt_q) >= NICKEL_MIN && 32'(cnt_q) <= NICKEL_MAX) begin
                    code_d  = COIN_5;
                    state_d = HOLD;
                end else if (32'(cnt_q) >= DIME_MIN && 32'(cnt_q) <= DIME_MAX) begin
                    code_d  = COIN_10;
                    state_d = HOLD;
                end else begin
                    reject_d = 1'b1;
                    cool_d   = '0;
                    state_d  = vend_pkg::COOLDOWN;
                end
            end

            // Keep the coin parked while the vending FSM is dispensing
            HOLD: begin
                if (!newspaper) begin
                    coin_d  = code_q;
                    count_d = accepted_count + 8'd1;
                    cool_d  = '0;
                    state_d = vend_pkg::COOLDOWN;
                end
            end

            vend_pkg::COOLDOWN: begin
                if (32'(cool_q) + 32'd1 >= COOLDOWN) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q + CNT_W'(1);
                end
            end

            JAM: begin
                if (sense_s) begin
                    jam_d = 1'b1;
                end else begin
                    cool_d  = '0;
                    state_d = vend_pkg::COOLDOWN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: widths, boundaries, dispense hold-off,
// jam, reset mid-measure and counter wrap.
module tb_coin_acceptor;

    logic       clock;
    logic       reset;
    logic       coin_sense;
    logic       newspaper;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic [7:0] accepted_count;

    int checks;
    int passes;
    int t;
    int n5, n10, nrej, njam;
    int first_coin, first_rej, first_jam;
    int n_bad;
    int exp_acc;

    coin_acceptor dut (
        .clock          (clock),
        .reset          (reset),
        .coin_sense     (coin_sense),
        .newspaper      (newspaper),
        .coin           (coin),
        .reject         (reject),
        .jam            (jam),
        .accepted_count (accepted_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic clr_watch();
        t = 0;
        n5 = 0; n10 = 0; nrej = 0; njam = 0;
        first_coin = -1; first_rej = -1; first_jam = -1;
    endtask

    // Advance n falling edges, tallying output activity with its time index
    task automatic step_watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            t++;
            if (coin == 2'b01) begin n5++;  if (first_coin < 0) first_coin = t; end
            if (coin == 2'b10) begin n10++; if (first_coin < 0) first_coin = t; end
            if (reject)        begin nrej++; if (first_rej < 0) first_rej = t; end
            if (jam)           begin njam++; if (first_jam < 0) first_jam = t; end
            if (coin == 2'b11 || (coin != 2'b00 && reject)) n_bad++;
        end
    endtask

    initial begin
        int w_tab[9];
        int c_tab[9];
        w_tab = '{3, 4, 8, 9, 10, 11, 12, 20, 21};
        c_tab = '{0, 1, 1, 0, 0, 0, 2, 2, 0};
        checks = 0; passes = 0; n_bad = 0; exp_acc = 0;
        reset = 1'b0; coin_sense = 1'b0; newspaper = 1'b0;
        clr_watch();

        // Reset state
        step_watch(3);
        chk("rst_coin", 32'(coin), 32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        chk("rst_jam", 32'(jam), 32'd0);
        chk("rst_count", 32'(accepted_count), 32'd0);
        reset = 1'b1;
        step_watch(3);

        // Nickel, 6 cycles
        clr_watch();
        coin_sense = 1'b1; step_watch(6);
        coin_sense = 1'b0; step_watch(10);
        exp_acc++;
        chk("nickel_n5", 32'(n5), 32'd1);
        chk("nickel_idx", 32'(first_coin), 32'd10);
        chk("nickel_rej", 32'(nrej), 32'd0);
        chk("nickel_count", 32'(accepted_count), 32'(exp_acc));

        // Dime, 15 cycles
        clr_watch();
        coin_sense = 1'b1; step_watch(15);
        coin_sense = 1'b0; step_watch(10);
        exp_acc++;
        chk("dime_n10", 32'(n10), 32'd1);
        chk("dime_n5", 32'(n5), 32'd0);
        chk("dime_count", 32'(accepted_count), 32'(exp_acc));

        // Width table: rejects and inclusive band edges
        for (int k = 0; k < 9; k++) begin
            clr_watch();
            coin_sense = 1'b1; step_watch(w_tab[k]);
            coin_sense = 1'b0; step_watch(10);
            chk($sformatf("w%0d_n5", w_tab[k]), 32'(n5), (c_tab[k] == 1) ? 32'd1 : 32'd0);
            chk($sformatf("w%0d_n10", w_tab[k]), 32'(n10), (c_tab[k] == 2) ? 32'd1 : 32'd0);
            chk($sformatf("w%0d_rej", w_tab[k]), 32'(nrej), (c_tab[k] == 0) ? 32'd1 : 32'd0);
            if (c_tab[k] == 0) begin
                chk($sformatf("w%0d_rej_idx", w_tab[k]), 32'(first_rej), 32'(w_tab[k] + 3));
            end else begin
                exp_acc++;
                chk($sformatf("w%0d_coin_idx", w_tab[k]), 32'(first_coin), 32'(w_tab[k] + 4));
            end
            chk($sformatf("w%0d_count", w_tab[k]), 32'(accepted_count), 32'(exp_acc));
        end

        // Dime held off by newspaper for 4 cycles
        clr_watch();
        coin_sense = 1'b1; step_watch(15);
        coin_sense = 1'b0; step_watch(2);
        newspaper = 1'b1; step_watch(4);
        chk("hold_no_coin", 32'(n5 + n10), 32'd0);
        newspaper = 1'b0; step_watch(1);
        chk("hold_release", 32'(coin), 32'd2);
        step_watch(1);
        chk("hold_one_cycle", 32'(coin), 32'd0);
        step_watch(8);
        exp_acc++;
        chk("hold_count", 32'(accepted_count), 32'(exp_acc));

        // Jam (80 cycles), then a pulse that rises during cooldown
        clr_watch();
        coin_sense = 1'b1; step_watch(80);
        coin_sense = 1'b0; step_watch(3);
        coin_sense = 1'b1; step_watch(6);
        coin_sense = 1'b0; step_watch(15);
        chk("jam_first", 32'(first_jam), 32'd66);
        chk("jam_len", 32'(njam), 32'd17);
        chk("jam_clear", 32'(jam), 32'd0);
        chk("jam_no_coin", 32'(n5 + n10), 32'd0);
        chk("jam_no_rej", 32'(nrej), 32'd0);
        chk("jam_count", 32'(accepted_count), 32'(exp_acc));

        // Reset mid-measure
        clr_watch();
        coin_sense = 1'b1; step_watch(7);
        reset = 1'b0; coin_sense = 1'b0;
        #1;
        chk("mid_rst_count", 32'(accepted_count), 32'd0);
        chk("mid_rst_coin", 32'(coin), 32'd0);
        chk("mid_rst_flags", 32'({reject, jam}), 32'd0);
        step_watch(2);
        reset = 1'b1;
        exp_acc = 0;
        step_watch(20);
        chk("mid_rst_silent", 32'(n5 + n10 + nrej), 32'd0);

        // 256 nickels wrap the counter
        clr_watch();
        for (int k = 0; k < 256; k++) begin
            coin_sense = 1'b1; step_watch(6);
            coin_sense = 1'b0; step_watch(8);
            if (k == 254) chk("wrap_255", 32'(accepted_count), 32'd255);
        end
        chk("wrap_n5", 32'(n5), 32'd256);
        chk("wrap_zero", 32'(accepted_count), 32'd0);
        chk("never_11_or_overlap", 32'(n_bad), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
